// File: rtl/dmem_block_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_block_ctrl
//   Memory-side responder for data-cache block fills and dirty write-backs.
//   Owns a MEM_DEPTH-word backing store. It serves one whole-block request at a
//   time. Each request waits a fixed MEM_LATENCY cycles, then moves one word per
//   cycle for BLOCK_SIZE cycles, then presents a response until it is taken.
//
// Ports
//   i_clk          clock, all state updates on posedge
//   i_rst          asynchronous active-high reset (memory contents are kept)
//   i_req_valid    request present
//   i_req_write    1 = write-back block, 0 = block fill
//   i_req_addr     word address; offset bits are ignored, wraps modulo MEM_DEPTH
//   i_req_block    write data; word offset k at [(BLOCK_SIZE-k)*WORD_SIZE-1 -: WORD_SIZE]
//   o_req_ready    controller can accept a request (IDLE)
//   o_resp_valid   response present (RESP)
//   i_resp_ready   requester takes the response
//   o_resp_write   type of the response being presented
//   o_resp_block   fill data, same ordering as i_req_block (offset 0 = MSW)
//   o_busy         controller is not IDLE
// -----------------------------------------------------------------------------
module dmem_block_ctrl #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned BLOCK_SIZE  = 4,
    parameter int unsigned BLOCK_INDEX = 2,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned MEM_LATENCY = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_req_valid,
    input  logic                            i_req_write,
    input  logic [WORD_SIZE-1:0]            i_req_addr,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0] i_req_block,
    output logic                            o_req_ready,
    output logic                            o_resp_valid,
    input  logic                            i_resp_ready,
    output logic                            o_resp_write,
    output logic [WORD_SIZE*BLOCK_SIZE-1:0] o_resp_block,
    output logic                            o_busy
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW = (BLOCK_INDEX > 0) ? BLOCK_INDEX : 1;
    localparam int unsigned LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [CW-1:0]        LastWord = CW'(BLOCK_SIZE - 1);
    localparam logic [LW-1:0]        LatInit  = LW'(MEM_LATENCY - 1);
    localparam logic [WORD_SIZE-1:0] OffMask  = WORD_SIZE'((1 << BLOCK_INDEX) - 1);
    localparam logic [WORD_SIZE-1:0] DepthW   = WORD_SIZE'(MEM_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StXfer,
        StResp
    } state_t;

    // Backing store: zero at time 0, never touched by reset.
    logic [WORD_SIZE-1:0] r_mem [MEM_DEPTH] = '{default: '0};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LW-1:0]        r_lat_cnt;
    logic [LW-1:0]        w_lat_nxt;
    logic [CW-1:0]        r_word_cnt;
    logic [CW-1:0]        w_word_nxt;
    logic                 r_write;
    logic [AW-1:0]        r_base;
    logic [WORD_SIZE-1:0] r_wr_words   [BLOCK_SIZE];
    logic [WORD_SIZE-1:0] r_resp_words [BLOCK_SIZE];

    logic                 w_accept;
    logic                 w_xfer;
    logic [WORD_SIZE-1:0] w_aligned;
    logic [AW-1:0]        w_base;
    logic [AW-1:0]        w_xfer_addr;

    // Block base: clear the offset bits, then wrap into the store. Because the
    // depth is a multiple of the block size the wrapped base stays aligned, so
    // base + word_cnt never leaves the store.
    assign w_aligned   = i_req_addr & ~OffMask;
    assign w_base      = AW'(w_aligned % DepthW);
    assign w_xfer_addr = r_base + AW'(r_word_cnt);

    // -------------------------------------------------------------------------
    // Next-state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_lat_nxt    = r_lat_cnt;
        w_word_nxt   = r_word_cnt;
        w_accept     = 1'b0;
        w_xfer       = 1'b0;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_resp_write = 1'b0;
        o_busy       = 1'b1;

        unique case (r_state)
            StIdle: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_lat_nxt   = LatInit;
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (r_lat_cnt == '0) begin
                    w_word_nxt  = '0;
                    w_state_nxt = StXfer;
                end else begin
                    w_lat_nxt = r_lat_cnt - 1'b1;
                end
            end
            StXfer: begin
                w_xfer = 1'b1;
                if (r_word_cnt == LastWord) begin
                    w_state_nxt = StResp;
                end else begin
                    w_word_nxt = r_word_cnt + 1'b1;
                end
            end
            StResp: begin
                o_resp_valid = 1'b1;
                o_resp_write = r_write;
                // Only the response completes here; a pending request waits
                // for the IDLE cycle that follows.
                if (i_resp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        o_resp_block = '0;
        for (int k = 0; k < int'(BLOCK_SIZE); k++) begin
            o_resp_block[(int'(BLOCK_SIZE) - k)*int'(WORD_SIZE) - 1 -: WORD_SIZE] = r_resp_words[k];
        end
    end

    // -------------------------------------------------------------------------
    // State and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_lat_cnt  <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat_cnt  <= w_lat_nxt;
            r_word_cnt <= w_word_nxt;
        end
    end

    // Latched request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_write <= 1'b0;
            r_base  <= '0;
            for (int k = 0; k < int'(BLOCK_SIZE); k++) begin
                r_wr_words[k] <= '0;
            end
        end else if (w_accept) begin
            r_write <= i_req_write;
            r_base  <= w_base;
            for (int k = 0; k < int'(BLOCK_SIZE); k++) begin
                r_wr_words[k] <= i_req_block[(int'(BLOCK_SIZE) - k)*int'(WORD_SIZE) - 1 -: WORD_SIZE];
            end
        end
    end

    // Fill data: only a read's XFER overwrites it, so it persists across writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < int'(BLOCK_SIZE); k++) begin
                r_resp_words[k] <= '0;
            end
        end else if (w_xfer && !r_write) begin
            r_resp_words[r_word_cnt] <= r_mem[w_xfer_addr];
        end
    end

    // Store write port. Reset forces IDLE, so an aborted write stops at once
    // with only the words already moved committed.
    always_ff @(posedge i_clk) begin
        if (w_xfer && r_write) begin
            r_mem[w_xfer_addr] <= r_wr_words[r_word_cnt];
        end
    end

endmodule

// File: tb/tb_dmem_block_ctrl.sv
module tb_dmem_block_ctrl;

    localparam int D = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_write, req_ready;
    logic [31:0]  req_addr;
    logic [127:0] req_block;
    logic         resp_valid, resp_ready, resp_write, busy;
    logic [127:0] resp_block;

    always #5 clk = ~clk;

    dmem_block_ctrl #(
        .WORD_SIZE  (32),
        .BLOCK_SIZE (4),
        .BLOCK_INDEX(2),
        .MEM_DEPTH  (D),
        .MEM_LATENCY(3)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_block (req_block),
        .o_req_ready (req_ready),
        .o_resp_valid(resp_valid),
        .i_resp_ready(resp_ready),
        .o_resp_write(resp_write),
        .o_resp_block(resp_block),
        .o_busy      (busy)
    );

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] blk;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic         wr;
        logic [127:0] blk;
    } exp_t;

    vec_t         vecs [6];
    exp_t         sb [$];
    logic [31:0]  mdl [D];
    logic [127:0] last_fill;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic int mbase(input logic [31:0] addr);
        return int'((addr & ~32'h3) % D);
    endfunction

    function automatic logic [127:0] mdl_read(input logic [31:0] addr);
        int b;
        b = mbase(addr);
        return {mdl[b], mdl[b+1], mdl[b+2], mdl[b+3]};
    endfunction

    task automatic mdl_write(input logic [31:0] addr, input logic [127:0] blk);
        int b;
        b = mbase(addr);
        mdl[b]   = blk[127:96];
        mdl[b+1] = blk[95:64];
        mdl[b+2] = blk[63:32];
        mdl[b+3] = blk[31:0];
    endtask

    // Drive one request from an idle controller; returns #1 after the accepting edge.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [127:0] blk,
                         input logic [127:0] exp);
        exp_t e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_block = blk;
        chk("req_ready_idle", {127'd0, req_ready}, 128'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.wr  = wr;
        e.blk = exp;
        sb.push_back(e);
        if (wr) mdl_write(addr, blk);
        else    last_fill = exp;
    endtask

    // Called #1 after the accepting edge; expects resp_valid after 7 more edges.
    task automatic wait_resp();
        int   cyc;
        logic low_ok;
        cyc    = 0;
        low_ok = 1'b1;
        while (!resp_valid && cyc < 50) begin
            if (req_ready || !busy) low_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 128'(cyc), 128'd7);
        chk("ready_low_while_busy", {127'd0, low_ok}, 128'd1);
    endtask

    task automatic complete();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 128'd0, 128'd1);
            e.wr  = 1'b0;
            e.blk = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("resp_valid", {127'd0, resp_valid}, 128'd1);
        chk("resp_write", {127'd0, resp_write}, {127'd0, e.wr});
        chk("resp_block", resp_block, e.blk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("idle_after_resp", {126'd0, resp_valid, req_ready}, 128'd1);
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [127:0] blk,
                           input logic [127:0] exp);
        issue(wr, addr, blk, exp);
        wait_resp();
        complete();
    endtask

    initial begin
        logic [127:0] snap;
        logic         stable_ok;
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] blk;

        for (int i = 0; i < D; i++) mdl[i] = '0;
        last_fill  = '0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_block  = '0;
        resp_ready = 1'b0;

        vecs[0] = '{1'b0, 32'd0,    128'd0, 128'd0};
        vecs[1] = '{1'b1, 32'd8,    {32'h11, 32'h22, 32'h33, 32'h44}, 128'd0};
        vecs[2] = '{1'b0, 32'd10,   128'd0, {32'h11, 32'h22, 32'h33, 32'h44}};
        vecs[3] = '{1'b1, 32'd1028, {32'd5, 32'd6, 32'd7, 32'd8}, {32'h11, 32'h22, 32'h33, 32'h44}};
        vecs[4] = '{1'b0, 32'd4,    128'd0, {32'd5, 32'd6, 32'd7, 32'd8}};
        vecs[5] = '{1'b0, 32'd1032, 128'd0, {32'h11, 32'h22, 32'h33, 32'h44}};

        // Reset state
        #2;
        chk("rst_outputs", {123'd0, req_ready, resp_valid, resp_write, busy, 1'b0}, 128'b10000);
        chk("rst_resp_block", resp_block, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven transactions (fill from zero, write/fill, wrap)
        foreach (vecs[i]) run_txn(vecs[i].wr, vecs[i].addr, vecs[i].blk, vecs[i].exp);

        // Response held for 5 cycles while a stray request is presented
        issue(1'b0, 32'd8, 128'd0, {32'h11, 32'h22, 32'h33, 32'h44});
        wait_resp();
        snap      = resp_block;
        stable_ok = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'd0;
        req_block = {4{32'hFFFF_FFFF}};
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!resp_valid || req_ready || resp_block !== snap) stable_ok = 1'b0;
        end
        chk("resp_hold_stable", {127'd0, stable_ok}, 128'd1);
        req_valid = 1'b0;
        complete();
        run_txn(1'b0, 32'd0, 128'd0, 128'd0);

        // Back-to-back: second request waits for the IDLE cycle after the response
        issue(1'b0, 32'd8, 128'd0, {32'h11, 32'h22, 32'h33, 32'h44});
        wait_resp();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'd4;
        begin
            exp_t e;
            e = sb.pop_front();
            chk("b2b_first_block", resp_block, e.blk);
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
            chk("b2b_not_same_cycle", {126'd0, resp_valid, req_ready}, 128'd1);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            chk("b2b_accept_next", {126'd0, req_ready, busy}, 128'd1);
            e.wr  = 1'b0;
            e.blk = {32'd5, 32'd6, 32'd7, 32'd8};
            sb.push_back(e);
            last_fill = e.blk;
            wait_resp();
            complete();
        end

        // Reset in the middle of a write's transfer
        run_txn(1'b1, 32'd12, {32'd1, 32'd2, 32'd3, 32'd4}, last_fill);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'd12;
        req_block = {4{32'd9}};
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midop_rst_outputs", {124'd0, req_ready, resp_valid, resp_write, busy}, 128'b1000);
        chk("midop_rst_block", resp_block, 128'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mdl[12]   = 32'd9;
        mdl[13]   = 32'd9;
        last_fill = '0;
        run_txn(1'b0, 32'd12, 128'd0, {32'd9, 32'd9, 32'd3, 32'd4});

        // Random traffic checked against the memory model
        for (int i = 0; i < 8; i++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 2047));
            blk  = {$urandom, $urandom, $urandom, $urandom};
            run_txn(wr, addr, blk, wr ? last_fill : mdl_read(addr));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
